// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC sequencer: FSM states, vector defaults and
// multi-cycle FP latency defaults.
package pc_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    FP_WAIT = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF   = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF    = 32'h0000_0100;
  localparam int          FP_DIV_CYCLES_DEF  = 12;
  localparam int          FP_SQRT_CYCLES_DEF = 16;

  // Counter width large enough for the longer of the two FP latencies.
  function automatic int cnt_width(input int div_cycles, input int sqrt_cycles);
    int longest;
    longest = (div_cycles > sqrt_cycles) ? div_cycles : sqrt_cycles;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter that saturates at zero; zero flags the final cycle.
module stall_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority over decrement, and zero holds.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush control, including the
// multi-cycle stall window for FDIV.S / FSQRT.S and trap capture of the PC.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR    = TRAP_VECTOR_DEF,
  parameter int          FP_DIV_CYCLES  = FP_DIV_CYCLES_DEF,
  parameter int          FP_SQRT_CYCLES = FP_SQRT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        hz_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic        fp_multi_start,
  input  logic        fp_multi_op,
  output logic [31:0] pc_next,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        fp_busy,
  output logic        fp_done,
  output logic        fp_abort,
  output logic [31:0] epc
);

  localparam int CNT_W = cnt_width(FP_DIV_CYCLES, FP_SQRT_CYCLES);
  // The issue cycle and the zero cycle are both stall cycles, hence N-2.
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(FP_DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(FP_SQRT_CYCLES - 2);

  pc_state_e        state_q;
  pc_state_e        state_d;
  logic [31:0]      epc_q;
  logic [31:0]      epc_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  stall_counter #(
    .W (CNT_W)
  ) u_stall_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Request resolution: next state, next PC, pipeline controls, counter and epc updates.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    pc_next      = pc + 32'd4;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    flush_fd     = 1'b0;
    flush_de     = 1'b0;
    fp_busy      = 1'b0;
    fp_done      = 1'b0;
    fp_abort     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = {CNT_W{1'b0}};
    cnt_dec      = 1'b0;
    if (!reset) begin
      // Outputs must settle to the reset image without waiting for a clock.
      state_d = RUN;
      epc_d   = 32'h0000_0000;
      pc_next = RESET_VECTOR;
    end else begin
      case (state_q)
        RUN: begin
          if (trap_req) begin
            pc_next  = TRAP_VECTOR;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            epc_d    = pc;
          end else if (br_taken) begin
            pc_next  = br_target;
            flush_fd = 1'b1;
            flush_de = 1'b1;
          end else if (fp_multi_start) begin
            pc_next      = pc;
            stall_f      = 1'b1;
            stall_d      = 1'b1;
            stall_e      = 1'b1;
            fp_busy      = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = fp_multi_op ? SQRT_LOAD : DIV_LOAD;
            state_d      = FP_WAIT;
          end else if (hz_stall) begin
            // Hold fetch/decode and inject a bubble into EX.
            pc_next  = pc;
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            flush_de = 1'b1;
          end else begin
            pc_next = pc + 32'd4;
          end
        end
        FP_WAIT: begin
          if (trap_req) begin
            // A trap kills the FP operation, even in its final cycle.
            pc_next      = TRAP_VECTOR;
            flush_fd     = 1'b1;
            flush_de     = 1'b1;
            fp_abort     = 1'b1;
            epc_d        = pc;
            cnt_load     = 1'b1;
            cnt_load_val = {CNT_W{1'b0}};
            state_d      = RUN;
          end else begin
            pc_next = pc;
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            fp_busy = 1'b1;
            cnt_dec = 1'b1;
            if (cnt_zero) begin
              fp_done = 1'b1;
              state_d = RUN;
            end else begin
              state_d = FP_WAIT;
            end
          end
        end
        default: begin
          pc_next = pc;
          state_d = RUN;
        end
      endcase
    end
  end

  // State and trap-PC registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      epc_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, branch, hazard, FP stall windows,
// trap aborts and reset during an FP operation.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        hz_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_req;
  logic        fp_multi_start;
  logic        fp_multi_op;
  logic [31:0] pc_next;
  logic        stall_f, stall_d, stall_e;
  logic        flush_fd, flush_de;
  logic        fp_busy, fp_done, fp_abort;
  logic [31:0] epc;
  logic [7:0]  ctrl;

  int checks = 0;
  int errors = 0;

  // {stall_f, stall_d, stall_e, flush_fd, flush_de, fp_busy, fp_done, fp_abort}
  localparam logic [7:0] C_NONE    = 8'b000_00_000;
  localparam logic [7:0] C_FLUSH   = 8'b000_11_000;
  localparam logic [7:0] C_HZ      = 8'b110_01_000;
  localparam logic [7:0] C_FP      = 8'b111_00_100;
  localparam logic [7:0] C_FP_DONE = 8'b111_00_110;
  localparam logic [7:0] C_ABORT   = 8'b000_11_001;

  assign ctrl = {stall_f, stall_d, stall_e, flush_fd, flush_de, fp_busy, fp_done, fp_abort};

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .hz_stall       (hz_stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .trap_req       (trap_req),
    .fp_multi_start (fp_multi_start),
    .fp_multi_op    (fp_multi_op),
    .pc_next        (pc_next),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_fd       (flush_fd),
    .flush_de       (flush_de),
    .fp_busy        (fp_busy),
    .fp_done        (fp_done),
    .fp_abort       (fp_abort),
    .epc            (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    hz_stall       = 1'b0;
    br_taken       = 1'b0;
    br_target      = 32'h0;
    trap_req       = 1'b0;
    fp_multi_start = 1'b0;
    fp_multi_op    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc    = 32'h20;
    idle_inputs();
    #3;
    checks++;
    if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next got %h want %h", pc_next, 32'h0); end
    checks++;
    if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_NONE); end
    checks++;
    if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want %h", epc, 32'h0); end
    // Requests during reset must not leak onto the outputs.
    trap_req = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (pc_next !== 32'h0 || ctrl !== C_NONE) begin
      errors++; $display("FAIL reset_masks_trap got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h0, C_NONE);
    end
    @(negedge clk);
    trap_req = 1'b0;
    reset    = 1'b1;
    pc       = 32'h0;
    #1;
    checks++;
    if (pc_next !== 32'h4 || ctrl !== C_NONE) begin
      errors++; $display("FAIL release_seq got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h4, C_NONE);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle_inputs();
    pc = 32'h10; br_taken = 1'b1; br_target = 32'h40; hz_stall = 1'b1; fp_multi_start = 1'b1;
    #1;
    checks++;
    if (pc_next !== 32'h40) begin errors++; $display("FAIL branch_pc got %h want %h", pc_next, 32'h40); end
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("FAIL branch_ctrl got %b want %b", ctrl, C_FLUSH); end
    // The ignored fp_multi_start must not have started an FP window.
    @(negedge clk);
    idle_inputs();
    pc = 32'h40;
    #1;
    checks++;
    if (pc_next !== 32'h44 || ctrl !== C_NONE) begin
      errors++; $display("FAIL branch_after got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h44, C_NONE);
    end
  endtask

  task automatic test_trap_run();
    @(negedge clk);
    idle_inputs();
    pc = 32'h24; trap_req = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    #1;
    checks++;
    if (pc_next !== 32'h100 || ctrl !== C_FLUSH) begin
      errors++; $display("FAIL trap_run got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h100, C_FLUSH);
    end
    @(negedge clk);
    idle_inputs();
    pc = 32'h100;
    #1;
    checks++;
    if (epc !== 32'h24) begin errors++; $display("FAIL trap_run_epc got %h want %h", epc, 32'h24); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    idle_inputs();
    pc = 32'h8; hz_stall = 1'b1;
    #1;
    checks++;
    if (pc_next !== 32'h8) begin errors++; $display("FAIL hazard_pc got %h want %h", pc_next, 32'h8); end
    checks++;
    if (ctrl !== C_HZ) begin errors++; $display("FAIL hazard_ctrl got %b want %b", ctrl, C_HZ); end
    @(negedge clk);
    idle_inputs();
    pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pc_next !== 32'h0 || ctrl !== C_NONE) begin
      errors++; $display("FAIL pc_wrap got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h0, C_NONE);
    end
  endtask

  task automatic test_fdiv();
    logic [31:0] exp_pc;
    logic [7:0]  exp_ctrl;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      idle_inputs();
      pc = 32'h30;
      if (c == 1) begin fp_multi_start = 1'b1; fp_multi_op = 1'b0; end
      else if (c == 4) begin br_taken = 1'b1; br_target = 32'h80; hz_stall = 1'b1; end
      else if (c == 6) begin fp_multi_start = 1'b1; fp_multi_op = 1'b1; end
      else begin idle_inputs(); end
      #1;
      exp_pc   = (c <= 12) ? 32'h30 : 32'h34;
      exp_ctrl = (c < 12) ? C_FP : ((c == 12) ? C_FP_DONE : C_NONE);
      checks++;
      if (pc_next !== exp_pc || ctrl !== exp_ctrl) begin
        errors++; $display("FAIL fdiv_cycle%0d got pc_next %h ctrl %b want %h %b", c, pc_next, ctrl, exp_pc, exp_ctrl);
      end
    end
  endtask

  task automatic test_sqrt_abort();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      idle_inputs();
      pc = 32'h50;
      if (c == 1) begin fp_multi_start = 1'b1; fp_multi_op = 1'b1; end
      #1;
      checks++;
      if (ctrl !== C_FP || pc_next !== 32'h50) begin
        errors++; $display("FAIL sqrt_cycle%0d got pc_next %h ctrl %b want %h %b", c, pc_next, ctrl, 32'h50, C_FP);
      end
    end
    @(negedge clk);
    idle_inputs();
    pc = 32'h58; trap_req = 1'b1;
    #1;
    checks++;
    if (pc_next !== 32'h100 || ctrl !== C_ABORT) begin
      errors++; $display("FAIL sqrt_abort got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h100, C_ABORT);
    end
    @(negedge clk);
    idle_inputs();
    pc = 32'h100;
    #1;
    checks++;
    if (epc !== 32'h58) begin errors++; $display("FAIL sqrt_abort_epc got %h want %h", epc, 32'h58); end
    checks++;
    if (ctrl !== C_NONE || pc_next !== 32'h104) begin
      errors++; $display("FAIL sqrt_after got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h104, C_NONE);
    end
  endtask

  task automatic test_trap_at_zero();
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      idle_inputs();
      pc = 32'h60;
      if (c == 1) begin fp_multi_start = 1'b1; fp_multi_op = 1'b0; end
      #1;
      checks++;
      if (ctrl !== C_FP) begin errors++; $display("FAIL tz_cycle%0d got %b want %b", c, ctrl, C_FP); end
    end
    @(negedge clk);
    idle_inputs();
    pc = 32'h70; trap_req = 1'b1;
    #1;
    checks++;
    if (pc_next !== 32'h100 || ctrl !== C_ABORT) begin
      errors++; $display("FAIL trap_at_zero got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h100, C_ABORT);
    end
    @(negedge clk);
    idle_inputs();
    pc = 32'h100;
    #1;
    checks++;
    if (epc !== 32'h70 || ctrl !== C_NONE) begin
      errors++; $display("FAIL trap_at_zero_after got epc %h ctrl %b want %h %b", epc, ctrl, 32'h70, C_NONE);
    end
  endtask

  task automatic test_reset_mid_fp();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_inputs();
      pc = 32'h90;
      if (c == 1) begin fp_multi_start = 1'b1; fp_multi_op = 1'b0; end
      #1;
      checks++;
      if (ctrl !== C_FP) begin errors++; $display("FAIL rmid_cycle%0d got %b want %b", c, ctrl, C_FP); end
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (pc_next !== 32'h0 || ctrl !== C_NONE || epc !== 32'h0) begin
      errors++; $display("FAIL rmid_async got pc_next %h ctrl %b epc %h want %h %b %h", pc_next, ctrl, epc, 32'h0, C_NONE, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ctrl !== C_NONE) begin errors++; $display("FAIL rmid_hold%0d got %b want %b", k, ctrl, C_NONE); end
    end
    @(negedge clk);
    reset = 1'b1;
    pc    = 32'h60;
    #1;
    checks++;
    if (pc_next !== 32'h64 || ctrl !== C_NONE) begin
      errors++; $display("FAIL rmid_release got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h64, C_NONE);
    end
    @(negedge clk);
    pc = 32'h64;
    #1;
    checks++;
    if (pc_next !== 32'h68 || ctrl !== C_NONE) begin
      errors++; $display("FAIL rmid_run got pc_next %h ctrl %b want %h %b", pc_next, ctrl, 32'h68, C_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_trap_run();
    test_hazard();
    test_fdiv();
    test_sqrt_abort();
    test_trap_at_zero();
    test_reset_mid_fp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
